pong_frame_render_ctrl: RTL and testbench

//  Per-frame render sequencer for the pong display path: on each frame_start it snapshots ball/paddle

---
 rtl/pong_frame_render_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pong_frame_render_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pong_frame_render_ctrl.sv
// Per-frame render sequencer: snapshots ball/paddle positions on frame_start, writes one colour per
// coarse-grid cell in raster order into the back buffer, then handshakes a front/back buffer swap.
module pong_frame_render_ctrl #(
    parameter int unsigned BIT_WIDTH     = 10,
    parameter int unsigned BALL_RADIUS   = 0,
    parameter int unsigned PADDLE_WIDTH  = 1,
    parameter int unsigned PADDLE_LENGTH = 3,
    parameter int unsigned HCELLS        = 32,
    parameter int unsigned VCELLS        = 24,
    parameter logic [11:0] C_BG          = 12'h000,
    parameter logic [11:0] C_BALL        = 12'hFFF,
    parameter logic [11:0] C_P1          = 12'hF00,
    parameter logic [11:0] C_P2          = 12'h00F
) (
    input  logic                 clk,
    input  logic                 sysRst,
    input  logic                 frame_start,
    input  logic [BIT_WIDTH-1:0] ball_x,
    input  logic [BIT_WIDTH-1:0] ball_y,
    input  logic [BIT_WIDTH-1:0] player1_x,
    input  logic [BIT_WIDTH-1:0] player1_y,
    input  logic [BIT_WIDTH-1:0] player2_x,
    input  logic [BIT_WIDTH-1:0] player2_y,
    output logic                 wr_en,
    output logic [9:0]           wr_addr,
    output logic [11:0]          wr_color,
    input  logic                 wr_ready,
    output logic                 swap_req,
    input  logic                 swap_ack,
    output logic                 busy,
    output logic                 overrun
);

    localparam int unsigned W  = BIT_WIDTH + 1;
    localparam int unsigned CW = (HCELLS > 1) ? $clog2(HCELLS) : 1;
    localparam int unsigned RW = (VCELLS > 1) ? $clog2(VCELLS) : 1;

    typedef logic [W-1:0] pos_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_SWAP
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    logic [9:0]             addr_q, addr_d;
    logic [11:0]            color_q, color_d;
    logic                   swap_q, swap_d;
    logic                   overrun_q, overrun_d;
    logic [BIT_WIDTH-1:0]   bx_q, by_q, p1x_q, p1y_q, p2x_q, p2y_q;
    logic [BIT_WIDTH-1:0]   bx_d, by_d, p1x_d, p1y_d, p2x_d, p2y_d;
    logic                   last_cell;

    // Lower bound saturates at zero; the extra bit keeps the upper bound from wrapping.
    function automatic logic in_span(input pos_t v, input pos_t ctr, input pos_t below,
                                     input pos_t above);
        pos_t lo;
        pos_t hi;
        lo = (ctr >= below) ? ctr - below : '0;
        hi = ctr + above;
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic logic [11:0] cell_colour(input pos_t c, input pos_t r,
                                                input pos_t bx, input pos_t by,
                                                input pos_t p1x, input pos_t p1y,
                                                input pos_t p2x, input pos_t p2y);
        logic [11:0] col;
        col = C_BG;
        if (in_span(c, p2x, '0, pos_t'(PADDLE_WIDTH)) &&
            in_span(r, p2y, pos_t'(PADDLE_LENGTH), pos_t'(PADDLE_LENGTH)))
            col = C_P2;
        if (in_span(c, p1x, '0, pos_t'(PADDLE_WIDTH)) &&
            in_span(r, p1y, pos_t'(PADDLE_LENGTH), pos_t'(PADDLE_LENGTH)))
            col = C_P1;
        if (in_span(c, bx, pos_t'(BALL_RADIUS), pos_t'(BALL_RADIUS)) &&
            in_span(r, by, pos_t'(BALL_RADIUS), pos_t'(BALL_RADIUS)))
            col = C_BALL;
        return col;
    endfunction

    assign last_cell = (col_q == CW'(HCELLS - 1)) && (row_q == RW'(VCELLS - 1));

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        addr_d    = addr_q;
        swap_d    = swap_q;
        overrun_d = overrun_q;
        bx_d      = bx_q;
        by_d      = by_q;
        p1x_d     = p1x_q;
        p1y_d     = p1y_q;
        p2x_d     = p2x_q;
        p2y_d     = p2y_q;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    bx_d    = ball_x;
                    by_d    = ball_y;
                    p1x_d   = player1_x;
                    p1y_d   = player1_y;
                    p2x_d   = player2_x;
                    p2y_d   = player2_y;
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (frame_start) overrun_d = 1'b1;
                if (wr_ready) begin
                    if (last_cell) begin
                        col_d   = '0;
                        row_d   = '0;
                        addr_d  = '0;
                        swap_d  = 1'b1;
                        state_d = S_SWAP;
                    end else if (col_q == CW'(HCELLS - 1)) begin
                        col_d  = '0;
                        row_d  = row_q + 1'b1;
                        addr_d = addr_q + 10'd1;
                    end else begin
                        col_d  = col_q + 1'b1;
                        addr_d = addr_q + 10'd1;
                    end
                end
            end
            S_SWAP: begin
                if (frame_start) overrun_d = 1'b1;
                if (swap_ack) begin
                    swap_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Colour is registered alongside the address, so it is computed for the next cell
        // from the next shadow values (covers the first cell on the frame_start edge).
        color_d = '0;
        if (state_d == S_SCAN)
            color_d = cell_colour(pos_t'(col_d), pos_t'(row_d), pos_t'(bx_d), pos_t'(by_d),
                                  pos_t'(p1x_d), pos_t'(p1y_d), pos_t'(p2x_d), pos_t'(p2y_d));
    end

    always_ff @(posedge clk or negedge sysRst) begin
        if (!sysRst) begin
            state_q   <= S_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            addr_q    <= '0;
            color_q   <= '0;
            swap_q    <= 1'b0;
            overrun_q <= 1'b0;
            bx_q      <= '0;
            by_q      <= '0;
            p1x_q     <= '0;
            p1y_q     <= '0;
            p2x_q     <= '0;
            p2y_q     <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            addr_q    <= addr_d;
            color_q   <= color_d;
            swap_q    <= swap_d;
            overrun_q <= overrun_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            p1x_q     <= p1x_d;
            p1y_q     <= p1y_d;
            p2x_q     <= p2x_d;
            p2y_q     <= p2y_d;
        end
    end

    assign wr_en    = (state_q == S_SCAN);
    assign wr_addr  = addr_q;
    assign wr_color = color_q;
    assign swap_req = swap_q;
    assign busy     = (state_q != S_IDLE);
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_pong_frame_render_ctrl.sv
// Directed bench for pong_frame_render_ctrl: full-frame sweeps with hand-chosen object layouts,
// back-pressure, mid-frame frame_start/position changes, swap handshake and async reset.
module tb_pong_frame_render_ctrl;

    localparam int CELLS = 768;

    logic        clk = 1'b0;
    logic        sysRst;
    logic        frame_start;
    logic [9:0]  ball_x, ball_y, player1_x, player1_y, player2_x, player2_y;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [11:0] wr_color;
    logic        wr_ready;
    logic        swap_req;
    logic        swap_ack;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int e_bx, e_by, e_p1x, e_p1y, e_p2x, e_p2y;
    logic exp_ovr = 1'b0;

    pong_frame_render_ctrl #(
        .BIT_WIDTH    (10),
        .BALL_RADIUS  (0),
        .PADDLE_WIDTH (1),
        .PADDLE_LENGTH(3),
        .HCELLS       (32),
        .VCELLS       (24)
    ) dut (
        .clk        (clk),
        .sysRst     (sysRst),
        .frame_start(frame_start),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .player1_x  (player1_x),
        .player1_y  (player1_y),
        .player2_x  (player2_x),
        .player2_y  (player2_y),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_color   (wr_color),
        .wr_ready   (wr_ready),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Rectangles in signed integers: off-grid lower bounds need no special handling.
    function automatic logic [11:0] model(input int a);
        int c;
        int r;
        c = a % 32;
        r = a / 32;
        if (c == e_bx && r == e_by) return 12'hFFF;
        if (c >= e_p1x && c <= e_p1x + 1 && r >= e_p1y - 3 && r <= e_p1y + 3) return 12'hF00;
        if (c >= e_p2x && c <= e_p2x + 1 && r >= e_p2y - 3 && r <= e_p2y + 3) return 12'h00F;
        return 12'h000;
    endfunction

    task automatic set_pos(input int bx, input int by, input int p1x, input int p1y,
                           input int p2x, input int p2y);
        ball_x = 10'(bx);     ball_y = 10'(by);
        player1_x = 10'(p1x); player1_y = 10'(p1y);
        player2_x = 10'(p2x); player2_y = 10'(p2y);
        e_bx = bx;   e_by = by;
        e_p1x = p1x; e_p1y = p1y;
        e_p2x = p2x; e_p2y = p2y;
    endtask

    task automatic run_frame(input bit rnd, input bit disturb, input int spot_a,
                             input logic [11:0] spot_c, input int exp_nonbg, input int ack_delay);
        int   exp_addr;
        int   cyc;
        int   nonbg;
        bit   fs_done;
        logic rdy;
        exp_addr = 0;
        cyc      = 0;
        nonbg    = 0;
        fs_done  = 0;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        check("busy_scan", 32'(busy), 32'd1);
        while (exp_addr < CELLS && cyc < 5000) begin
            check("wr_en", 32'(wr_en), 32'd1);
            check("wr_addr", 32'(wr_addr), 32'(exp_addr));
            check("wr_color", 32'(wr_color), 32'(model(exp_addr)));
            if (exp_addr == spot_a) check("spot_color", 32'(wr_color), 32'(spot_c));
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_ready = rdy;
            if (disturb && !fs_done && exp_addr >= 400) begin
                frame_start = 1'b1;
                ball_x = 10'd0;     ball_y = 10'd0;
                player1_x = 10'd20; player1_y = 10'd20;
                fs_done = 1;
                exp_ovr = 1'b1;
            end
            if (rdy && wr_color != 12'h000) nonbg++;
            @(posedge clk); #1;
            frame_start = 1'b0;
            if (rdy) exp_addr++;
            cyc++;
        end
        check("scan_complete", 32'(exp_addr), 32'(CELLS));
        check("end_wr_en", 32'(wr_en), 32'd0);
        check("swap_req_set", 32'(swap_req), 32'd1);
        check("nonbg_cells", 32'(nonbg), 32'(exp_nonbg));
        check("overrun", 32'(overrun), 32'(exp_ovr));
        for (int i = 0; i < ack_delay; i++) begin
            if (disturb && i == 1) frame_start = 1'b1;
            @(posedge clk); #1;
            frame_start = 1'b0;
            check("swap_hold", 32'(swap_req), 32'd1);
            check("busy_swap", 32'(busy), 32'd1);
        end
        swap_ack = 1'b1;
        frame_start = disturb;
        @(posedge clk); #1;
        swap_ack = 1'b0;
        frame_start = 1'b0;
        check("swap_released", 32'(swap_req), 32'd0);
        check("busy_after_ack", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_wr_en", 32'(wr_en), 32'd0);
            check("idle_swap", 32'(swap_req), 32'd0);
            check("idle_overrun", 32'(overrun), 32'(exp_ovr));
        end
    endtask

    initial begin
        sysRst      = 1'b0;
        frame_start = 1'b0;
        wr_ready    = 1'b1;
        swap_ack    = 1'b0;
        set_pos(40, 40, 40, 10, 40, 10);
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_color", 32'(wr_color), 32'd0);
        check("rst_swap_req", 32'(swap_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        sysRst = 1'b1;
        @(posedge clk); #1;

        // swap_ack outside SWAP has no effect
        swap_ack = 1'b1;
        @(posedge clk); #1;
        swap_ack = 1'b0;
        check("stray_ack_busy", 32'(busy), 32'd0);

        // single-cell ball, paddles off-grid
        set_pos(5, 7, 40, 10, 40, 10);
        run_frame(0, 0, 229, 12'hFFF, 1, 2);
        // paddle1 clipped at the top edge
        set_pos(40, 40, 1, 2, 40, 10);
        run_frame(0, 0, 162, 12'hF00, 12, 0);
        // ball inside paddle1
        set_pos(1, 3, 1, 2, 40, 10);
        run_frame(0, 0, 97, 12'hFFF, 12, 1);
        // back-pressure, objects at bottom-right and top-left corners
        set_pos(31, 23, 0, 0, 30, 22);
        run_frame(1, 0, 767, 12'hFFF, 18, 3);
        // overlapping paddles, frame_start and new positions mid-frame
        set_pos(10, 10, 3, 12, 4, 12);
        run_frame(0, 1, 388, 12'hF00, 22, 3);
        // positions changed last frame take effect now
        set_pos(0, 0, 20, 20, 4, 12);
        run_frame(0, 0, 0, 12'hFFF, 29, 1);

        // async reset mid-scan at cell 300
        set_pos(12, 9, 40, 10, 40, 10);
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        wr_ready = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check("pre_rst_addr", 32'(wr_addr), 32'd300);
        check("pre_rst_color", 32'(wr_color), 32'hFFF);
        check("pre_rst_overrun", 32'(overrun), 32'd1);
        #2 sysRst = 1'b0;
        #1;
        check("arst_wr_en", 32'(wr_en), 32'd0);
        check("arst_wr_addr", 32'(wr_addr), 32'd0);
        check("arst_wr_color", 32'(wr_color), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_overrun", 32'(overrun), 32'd0);
        check("arst_swap_req", 32'(swap_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_hold_swap", 32'(swap_req), 32'd0);
            check("rst_hold_wr_en", 32'(wr_en), 32'd0);
        end
        sysRst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_busy", 32'(busy), 32'd0);
            check("post_rst_swap", 32'(swap_req), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
